// File: rtl/program_memory_read_arbiter.sv
// Purpose : round-robin arbiter sharing the read-only port B of program memory
//           between NUM_REQ requesters. Each read carries an ID tag that routes
//           the returned word back to the requester that issued it.
// Latency : grant at cycle T -> read request at T+1 -> resp_valid_out at T+2+READ_LATENCY.
// Backpr. : requests are held off by req_ready_out, one grant per cycle. Responses
//           have no backpressure, so requesters must sink resp_valid_out.
// Ports   :
//   clk_in, rst_in           clock, async active-high reset
//   enable_in                grants allowed only once program memory is loaded
//   req_valid_in/addr_in     per-requester request, 32-bit byte address per lane
//   req_ready_out            one-hot grant (transfer on valid & ready)
//   resp_valid_out/data_out  one-hot response strobe and shared returned word
//   mem_*                    port-B side of the program memory
//   error_out                sticky; a response/tag misalignment was seen
module program_memory_read_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 2,
  parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [NUM_REQ-1:0]    req_valid_in,
  input  logic [NUM_REQ*32-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]    req_ready_out,
  output logic [NUM_REQ-1:0]    resp_valid_out,
  output logic [31:0]           resp_data_out,
  output logic [31:0]           mem_addr_out,
  output logic                  mem_read_request_out,
  input  logic [31:0]           mem_instr_in,
  input  logic                  mem_data_valid_in,
  output logic                  error_out
);

  // Ownership tag that travels alongside each outstanding read.
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [ID_W-1:0]              ptr;
  logic [ID_W-1:0]              gnt_id;
  logic [ID_W-1:0]              next_ptr;
  logic                         gnt_any;
  logic [31:0]                  gnt_addr;
  tag_t                         issue_tag;
  tag_t [READ_LATENCY-1:0]      tag_pipe;
  tag_t                         tail_tag;
  logic [NUM_REQ-1:0]           resp_onehot;
  logic                         resp_take;

  // Requester index modulo NUM_REQ. Inputs never exceed 2*NUM_REQ-1, so a
  // single conditional subtract suffices.
  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    int w;
    w = (v >= NUM_REQ) ? (v - NUM_REQ) : v;
    return ID_W'(w);
  endfunction

  // Round-robin search starting at ptr. The first valid requester found wins.
  always_comb begin
    req_ready_out = '0;
    gnt_any       = 1'b0;
    gnt_id        = '0;
    if (enable_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req_valid_in[wrap_idx(int'(ptr) + k)]) begin
          gnt_any = 1'b1;
          gnt_id  = wrap_idx(int'(ptr) + k);
        end
      end
      if (gnt_any) begin
        req_ready_out[gnt_id] = 1'b1;
      end
    end
  end

  assign gnt_addr = req_addr_in[int'(gnt_id)*32 +: 32];
  assign next_ptr = wrap_idx(int'(gnt_id) + 1);

  // Issue stage: the registered request doubles as the head of the tag pipe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr          <= '0;
      mem_addr_out <= '0;
      issue_tag    <= '0;
    end else begin
      if (gnt_any) begin
        ptr          <= next_ptr;
        mem_addr_out <= gnt_addr;
      end
      issue_tag.vld <= gnt_any;
      issue_tag.id  <= gnt_id;
    end
  end

  assign mem_read_request_out = issue_tag.vld;

  // The tail stage lines up with the memory's data_valid for the same read.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tail_tag  = tag_pipe[READ_LATENCY-1];
  assign resp_take = tail_tag.vld && mem_data_valid_in;

  always_comb begin
    resp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_onehot[i] = resp_take && (int'(tail_tag.id) == i);
    end
  end

  // Response stage. Any disagreement between the tag pipe and the memory's
  // valid flag means the two pipelines are out of step; it is latched, and
  // the untagged word is dropped rather than misrouted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      resp_valid_out <= '0;
      resp_data_out  <= '0;
      error_out      <= 1'b0;
    end else begin
      resp_valid_out <= resp_onehot;
      if (resp_take) begin
        resp_data_out <= mem_instr_in;
      end
      if (tail_tag.vld != mem_data_valid_in) begin
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: doc/program_memory_read_arbiter.md
Name: program_memory_read_arbiter

Overview:
- Shares the second (read-only) port of the program memory between NUM_REQ requesters, e.g. CPU data-side loads from rodata and the sprite/tile fetcher.
- Arbitrates round-robin and issues at most one read per cycle to the port.
- Tracks which requester owns each in-flight read, and routes each returning instruction word back to its owner.
- Sits between the requesters and the port-B side of the program memory bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- READ_LATENCY, 2, cycles from memory read_request to data_valid; must match the program memory.
- ID_W, $clog2(NUM_REQ) (min 1), requester ID width used internally for tags.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- enable_in  input  1  high once program memory has finished loading; no grants while low.
- req_valid_in  input  NUM_REQ  per-requester read request.
- req_addr_in  input  NUM_REQ*32  per-requester byte address; requester i occupies bits [32i+31:32i].
- req_ready_out  output  NUM_REQ  one-hot grant; a transfer occurs when valid & ready.
- resp_valid_out  output  NUM_REQ  one-hot; pulses for one cycle when requester i's data is on resp_data_out.
- resp_data_out  output  32  returned instruction word, shared by all requesters.
- mem_addr_out  output  32  to program memory addr_b.
- mem_read_request_out  output  1  to program memory read_request_b.
- mem_instr_in  input  32  from program memory instr_b.
- mem_data_valid_in  input  1  from program memory data_valid_b.
- error_out  output  1  sticky; set on a response with no matching tag.

Behaviour:
- Reset (async, rst_in=1):
  - all outputs 0; round-robin pointer = 0.
  - tag pipeline cleared; error_out cleared.
  - In-flight reads are abandoned. Responses arriving after reset deasserts carry no tag, so they assert error_out; the integrator resets the memory valid pipe with the same reset.
- Grant (combinational):
  - If enable_in=0 or no valid request, req_ready_out=0.
  - Otherwise grant the first i with req_valid_in[i]=1, searching ptr, ptr+1, …, wrapping mod NUM_REQ.
  - req_ready_out depends only on req_valid_in, ptr and enable_in.
- Pointer: on a grant to i, ptr <= (i+1) mod NUM_REQ next cycle; unchanged when there is no grant.
- Issue (registered): on a grant at cycle T:
  - mem_addr_out <= granted address, unmodified (the memory ignores bits [1:0]);
  - mem_read_request_out = 1 in cycle T+1.
  - With no grant, mem_read_request_out=0 and mem_addr_out holds its last value.
- Tag pipeline:
  - READ_LATENCY-stage shift of {valid, ID} launched with mem_read_request_out.
  - The tail stage aligns with mem_data_valid_in (cycle T+1+READ_LATENCY).
- Response (registered):
  - When mem_data_valid_in=1 and the tail tag is valid with ID k: in the next cycle resp_valid_out = one-hot k and resp_data_out = mem_instr_in.
  - Total latency is grant at T to resp_valid at T+2+READ_LATENCY (T+4 by default).
  - resp_data_out holds its value when no response is returned.
- Throughput: one grant per cycle and up to READ_LATENCY+2 reads in flight. No backpressure on responses; requesters must sink resp_valid_out.
- Ordering: responses return in issue order, both globally and per requester.
- Error case: mem_data_valid_in=1 with an invalid tail tag sets error_out (sticky until reset) and produces no response. A valid tail tag without mem_data_valid_in also sets error_out.
- enable_in dropping mid-stream blocks new grants only; in-flight reads still complete and are routed.
- Simultaneous requests:
  - exactly one grant per cycle;
  - a requester holding valid is granted within NUM_REQ cycles (starvation-free).

Test Plan:
- Single read: enable=1, req0 addr 0x0000_0010 for one cycle; memory model returns 0xDEADBEEF with latency 2 → req_ready_out=01 at T, mem_read_request_out at T+1 with addr 0x10, resp_valid_out=01 at T+4 with data 0xDEADBEEF.
- Contention: req0 and req1 held high for 6 cycles with distinct addresses → grants 01,10,01,10,01,10; responses alternate in the same order, each with the correct data.
- Back-to-back single requester: req1 high for 8 cycles, addresses 0x0,0x4,…,0x1C → 8 consecutive mem_read_request pulses and 8 consecutive resp_valid_out=10 pulses, in address order.
- Enable gating: enable_in=0 while req0 is valid → no req_ready_out and no mem_read_request_out. Raise enable_in → grant in the same cycle.
- Reset mid-flight: issue 2 reads, assert rst_in asynchronously for 1 cycle between the memory request and the response; the memory model is also reset → all outputs 0 immediately, no resp_valid_out, error_out=0.
- Spurious response: force mem_data_valid_in=1 with no outstanding read → error_out=1 and remains 1, resp_valid_out stays 0.
